// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {ST_INIT, ST_RUN} st_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: size_to_be = 4'b0001 << lane;
            SZ_HALF: size_to_be = 4'b0011 << lane;
            SZ_WORD: size_to_be = 4'hF;
            default: size_to_be = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering: store data replication/byte enables and load extraction/extension.
module byte_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [15:0] shifted;

    assign st_be = size_to_be(st_size, st_lane);

    // Every lane carries a copy of the right-aligned data; byte enables pick the live ones.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign st_wdata[8*gi +: 8] = (st_size == SZ_BYTE) ? st_data[7:0] :
                                     (st_size == SZ_HALF) ? st_data[8*(gi%2) +: 8] :
                                                            st_data[8*gi +: 8];
    end

    assign shifted = 16'(ld_word >> {ld_lane, 3'b000});

    always_comb begin
        ld_data = '0;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = ld_unsigned ? {16'h0, shifted}
                                           : {{16{shifted[15]}}, shifted};
            SZ_WORD: ld_data = ld_word;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_pipe.sv
// MEM-stage data memory: byte/half/word access, zero-fill after reset,
// fixed-latency response pipeline with error reporting.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              resp_valid,
    output logic              resp_err
);

    st_e               state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_reg;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;

    logic              s0_valid_reg, s0_err_reg, s0_load_reg, s0_uns_reg;
    logic [1:0]        s0_size_reg, s0_lane_reg;
    resp_t             resp0, resp_out;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + ADDR_W'(1);
                if (cnt_reg == ADDR_W'(DEPTH - 1))
                    state_next = ST_RUN;
            end
            ST_RUN:  req_ready = 1'b1;
            default: state_next = ST_INIT;
        endcase
    end

    assign accept   = req_valid & req_ready;
    assign word_idx = address[ADDR_W+1:2];
    assign req_err  = (req_size == 2'b11) |
                      ((req_size == SZ_HALF) & address[0]) |
                      ((req_size == SZ_WORD) & (|address[1:0])) |
                      (|address[31:ADDR_W+2]);

    byte_lane_align u_align (
        .st_size     (req_size),
        .st_lane     (address[1:0]),
        .st_data     (writeData),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_size     (s0_size_reg),
        .ld_lane     (s0_lane_reg),
        .ld_unsigned (s0_uns_reg),
        .ld_word     (rd_word_reg),
        .ld_data     (ld_data)
    );

    // The zero-fill sweep owns the write port until the FSM reaches RUN.
    always_comb begin
        if (state_reg == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_reg;
            mem_be    = 4'hF;
            mem_wdata = '0;
        end else begin
            mem_we    = accept & req_write & ~req_err;
            mem_addr  = word_idx;
            mem_be    = st_be;
            mem_wdata = st_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && mem_be[i])
                mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        rd_word_reg <= mem[word_idx];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s0_valid_reg <= 1'b0;
            s0_err_reg   <= 1'b0;
            s0_load_reg  <= 1'b0;
            s0_uns_reg   <= 1'b0;
            s0_size_reg  <= SZ_BYTE;
            s0_lane_reg  <= 2'b00;
        end else begin
            s0_valid_reg <= accept;
            s0_err_reg   <= req_err;
            s0_load_reg  <= ~req_write;
            s0_uns_reg   <= req_unsigned;
            s0_size_reg  <= req_size;
            s0_lane_reg  <= address[1:0];
        end
    end

    assign resp0.valid = s0_valid_reg;
    assign resp0.err   = s0_valid_reg & s0_err_reg;
    assign resp0.data  = (s0_valid_reg & ~s0_err_reg & s0_load_reg) ? ld_data : 32'h0;

    if (LATENCY == 1) begin : g_direct
        assign resp_out = resp0;
    end else begin : g_pipe
        resp_t sr_reg [LATENCY-1];

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int i = 0; i < LATENCY - 1; i++)
                    sr_reg[i] <= '0;
            end else begin
                sr_reg[0] <= resp0;
                for (int i = 1; i < LATENCY - 1; i++)
                    sr_reg[i] <= sr_reg[i-1];
            end
        end

        assign resp_out = sr_reg[LATENCY-2];
    end

    assign resp_valid = resp_out.valid;
    assign resp_err   = resp_out.err;
    assign readData   = resp_out.data;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench: two instances (LATENCY 1 and 3) share stimulus; expected values are hand-computed.
module tb_data_mem_pipe;
    import data_mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_unsigned = 1'b0;
    logic [1:0]  req_size = SZ_WORD;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;

    logic        rdy1, rv1, re1, rdy3, rv3, re3;
    logic [31:0] rd1, rd3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    data_mem_pipe #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .LATENCY(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(rdy1),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .writeData(writeData), .readData(rd1),
        .resp_valid(rv1), .resp_err(re1)
    );

    data_mem_pipe #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .LATENCY(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(rdy3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .address(address), .writeData(writeData), .readData(rd3),
        .resp_valid(rv3), .resp_err(re3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request; checks the LATENCY=1 response, its single-cycle pulse, then the LATENCY=3 response.
    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        @(negedge CLK);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        address = addr; writeData = wd;
        chk({tag, ".rdy1"}, 32'(rdy1), 32'd1);
        chk({tag, ".rdy3"}, 32'(rdy3), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        chk({tag, ".v1"}, 32'(rv1), 32'd1);
        chk({tag, ".e1"}, 32'(re1), 32'(exp_e));
        chk({tag, ".d1"}, rd1, exp_d);
        @(negedge CLK);
        chk({tag, ".v1off"}, 32'(rv1), 32'd0);
        chk({tag, ".v3early"}, 32'(rv3), 32'd0);
        @(negedge CLK);
        chk({tag, ".v3"}, 32'(rv3), 32'd1);
        chk({tag, ".e3"}, 32'(re3), 32'(exp_e));
        chk({tag, ".d3"}, rd3, exp_d);
        $display("txn %s wr=%0d sz=%0d addr=%h wd=%h rd1=%h rd3=%h err=%0d/%0d",
                 tag, wr, sz, addr, wd, rd1, rd3, re1, re3);
    endtask

    // Checks that req_ready stays low for exactly 32 cycles after release, with no responses.
    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 32; i++) begin
            @(negedge CLK);
            chk($sformatf("%s.rdy1_%0d", tag, i), 32'(rdy1), (i < 32) ? 32'd0 : 32'd1);
            chk($sformatf("%s.rdy3_%0d", tag, i), 32'(rdy3), (i < 32) ? 32'd0 : 32'd1);
            chk($sformatf("%s.rv3_%0d", tag, i), 32'(rv3), 32'd0);
        end
        $display("txn %s sweep: ready rose after 32 cycles check done", tag);
    endtask

    initial begin
        // T1: reset, zero-fill sweep, then loads of freshly cleared memory
        repeat (3) @(negedge CLK);
        chk("rst.rdy1", 32'(rdy1), 32'd0);
        chk("rst.rv1", 32'(rv1), 32'd0);
        chk("rst.rd3", rd3, 32'd0);
        chk("rst.re3", 32'(re3), 32'd0);
        RST_N = 1'b1;
        sweep_check("t1");
        txn("t1.ld00", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);
        txn("t1.ld40", 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
        txn("t1.ld7c", 1'b0, SZ_WORD, 1'b0, 32'h7C, 32'h0, 32'h0, 1'b0);

        // T2: word store, signed/unsigned byte loads
        txn("t2.stw", 1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("t2.lbs", 1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0, 32'hFFFFFFBE, 1'b0);
        txn("t2.lbu", 1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0, 32'h000000BE, 1'b0);

        // T3: half store merges into upper lanes
        txn("t3.sth", 1'b1, SZ_HALF, 1'b0, 32'h0A, 32'hFFFF1234, 32'h0, 1'b0);
        txn("t3.lw", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 32'h1234BEEF, 1'b0);
        txn("t3.lhs", 1'b0, SZ_HALF, 1'b0, 32'h08, 32'h0, 32'hFFFFBEEF, 1'b0);
        txn("t3.lhu", 1'b0, SZ_HALF, 1'b1, 32'h08, 32'h0, 32'h0000BEEF, 1'b0);
        txn("t3.lhs_hi", 1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, 32'h00001234, 1'b0);

        // Byte store into lane 1 preserves the other lanes
        txn("bs.stw0", 1'b1, SZ_WORD, 1'b0, 32'h00, 32'hA5A50001, 32'h0, 1'b0);
        txn("bs.stw4", 1'b1, SZ_WORD, 1'b0, 32'h04, 32'h00007F02, 32'h0, 1'b0);
        txn("bs.stb5", 1'b1, SZ_BYTE, 1'b0, 32'h05, 32'h00000077, 32'h0, 1'b0);
        txn("bs.lw4", 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 32'h00007702, 1'b0);

        // T4: error cases leave memory untouched
        txn("t4.lh3", 1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1);
        txn("t4.stw80", 1'b1, SZ_WORD, 1'b0, 32'h80, 32'hCAFEF00D, 32'h0, 1'b1);
        txn("t4.lw0", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'hA5A50001, 1'b0);
        txn("t4.sz3", 1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1);
        txn("t4.sth9", 1'b1, SZ_HALF, 1'b0, 32'h09, 32'h00005555, 32'h0, 1'b1);
        txn("t4.stw6", 1'b1, SZ_WORD, 1'b0, 32'h06, 32'h66666666, 32'h0, 1'b1);
        txn("t4.lw8", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 32'h1234BEEF, 1'b0);
        txn("t4.lw4", 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 32'h00007702, 1'b0);

        // T5: back-to-back loads, in-order responses at fixed latency
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; address = 32'h0;
        @(negedge CLK);
        address = 32'h4;
        chk("t5.d1a", rd1, 32'hA5A50001);
        chk("t5.v3n1", 32'(rv3), 32'd0);
        @(negedge CLK);
        address = 32'h8;
        chk("t5.d1b", rd1, 32'h00007702);
        chk("t5.v3n2", 32'(rv3), 32'd0);
        @(negedge CLK);
        req_valid = 1'b0;
        chk("t5.d1c", rd1, 32'h1234BEEF);
        chk("t5.v3a", 32'(rv3), 32'd1);
        chk("t5.d3a", rd3, 32'hA5A50001);
        @(negedge CLK);
        chk("t5.v1off", 32'(rv1), 32'd0);
        chk("t5.v3b", 32'(rv3), 32'd1);
        chk("t5.d3b", rd3, 32'h00007702);
        @(negedge CLK);
        chk("t5.v3c", 32'(rv3), 32'd1);
        chk("t5.d3c", rd3, 32'h1234BEEF);
        @(negedge CLK);
        chk("t5.v3off", 32'(rv3), 32'd0);
        $display("txn t5 back-to-back loads 0x0,0x4,0x8 checked");

        // T6: reset with two responses pending, then a reset mid-sweep
        @(negedge CLK);
        req_valid = 1'b1; address = 32'h0;
        @(negedge CLK);
        address = 32'h4;
        @(negedge CLK);
        req_valid = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("t6.rv3_async", 32'(rv3), 32'd0);
        chk("t6.rv1_async", 32'(rv1), 32'd0);
        chk("t6.rdy3_async", 32'(rdy3), 32'd0);
        chk("t6.rd3_async", rd3, 32'd0);
        repeat (3) begin
            @(negedge CLK);
            chk("t6.rv3_inrst", 32'(rv3), 32'd0);
        end
        RST_N = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            chk($sformatf("t6.pre_rv3_%0d", i), 32'(rv3), 32'd0);
            chk($sformatf("t6.pre_rdy3_%0d", i), 32'(rdy3), 32'd0);
        end
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        sweep_check("t6");
        txn("t6.lw8", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
        txn("t6.lw0", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
